// File: rtl/mem_arbiter.sv
// Two-port controller for a single-port synchronous data memory: fetch (read-only) and
// load/store share the array under round-robin arbitration, after an optional zero-fill sweep.
module mem_arbiter #(
  parameter int AW             = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic [31:0]   mem_bwen,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_d,
  input  logic [31:0]   mem_q,
  output logic          init_done
);

  typedef enum logic {CLEAR, RUN} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t        state;
  port_t         last_gnt;
  logic [AW-1:0] clr_cnt;

  // Only word-address bits reach the memory; the rest are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

  assign i_rdata = mem_q;
  assign d_rdata = mem_q;

  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    mem_cen  = 1'b1;
    mem_wen  = 1'b1;
    mem_bwen = '0;
    mem_a    = '0;
    mem_d    = '0;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_cen  = 1'b0;
        mem_wen  = 1'b0;
        mem_bwen = '1;
        mem_a    = clr_cnt;
      end else begin
        // On a conflict the port that did not win last time gets the memory.
        if (i_req && d_req) begin
          d_gnt = (last_gnt == PORT_I);
          i_gnt = !d_gnt;
        end else begin
          i_gnt = i_req;
          d_gnt = d_req;
        end
        mem_cen = ~(i_gnt | d_gnt);
        mem_wen = ~(d_gnt & d_we);
        mem_a   = d_gnt ? d_addr[AW+1:2] : i_addr[AW+1:2];
        mem_d   = d_wdata;
        if (d_gnt && d_we) begin
          for (int k = 0; k < 4; k++) begin
            mem_bwen[8*k +: 8] = {8{d_be[k]}};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt   <= '0;
      last_gnt  <= PORT_D;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      i_rvalid <= i_gnt;
      d_rvalid <= d_gnt & ~d_we;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          init_done <= 1'b1;
          if (i_gnt) begin
            last_gnt <= PORT_I;
          end else if (d_gnt) begin
            last_gnt <= PORT_D;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory, a spec-level reference model checked every
// cycle, and directed scenarios with literal expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, init_done;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_cen, mem_wen;
  logic [31:0] mem_bwen, mem_d, mem_q;
  logic [7:0]  mem_a;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_bwen(mem_bwen), .mem_a(mem_a),
    .mem_d(mem_d), .mem_q(mem_q), .init_done(init_done)
  );

  // Behavioural 256x32 single-port memory with per-bit write mask and 1-cycle read.
  logic [31:0] dev_mem [256];
  initial for (int i = 0; i < 256; i++) dev_mem[i] = 32'hFFFF_FFFF;
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) dev_mem[mem_a] <= (dev_mem[mem_a] & ~mem_bwen) | (mem_d & mem_bwen);
      else          mem_q <= dev_mem[mem_a];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: sweep cycles left, last winner, pending read responses, array contents.
  bit          model_valid = 0;
  int          clear_left;
  bit          done_q, prev_d, exp_irv, exp_drv;
  logic [31:0] exp_ird, exp_drd;
  logic [31:0] shadow [256];

  always @(negedge clk) begin
    bit          any, win_d, e_i, e_d, e_cen, e_wen;
    logic [7:0]  e_a;
    logic [31:0] e_bwen, e_d_data;
    if (rst || model_valid) begin
      e_i = 0; e_d = 0; e_cen = 1; e_wen = 1; e_a = 0; e_bwen = 0; e_d_data = 0;
      if (!rst && clear_left > 0) begin
        e_cen = 0; e_wen = 0; e_bwen = 32'hFFFF_FFFF; e_a = 8'(256 - clear_left);
      end else if (!rst) begin
        any   = i_req || d_req;
        win_d = (i_req && d_req) ? !prev_d : d_req;
        e_i   = any && !win_d;
        e_d   = any && win_d;
        e_cen = !any;
        e_wen = !(e_d && d_we);
        e_a   = 8'(((e_d ? d_addr : i_addr) / 4) % 256);
        e_d_data = d_wdata;
        if (e_d && d_we) for (int b = 0; b < 32; b++) e_bwen[b] = d_be[b/8];
      end
      checkOutput("i_gnt", i_gnt, e_i);
      checkOutput("d_gnt", d_gnt, e_d);
      checkOutput("mem_cen", mem_cen, e_cen);
      if (!e_cen) begin
        checkOutput("mem_wen", mem_wen, e_wen);
        checkOutput("mem_a", mem_a, e_a);
        if (!e_wen) begin
          checkOutput("mem_bwen", mem_bwen, e_bwen);
          checkOutput("mem_d", mem_d, e_d_data);
        end
      end
      if (model_valid) begin
        checkOutput("init_done", init_done, done_q);
        checkOutput("i_rvalid", i_rvalid, exp_irv);
        checkOutput("d_rvalid", d_rvalid, exp_drv);
        if (exp_irv) checkOutput("i_rdata", i_rdata, exp_ird);
        if (exp_drv) checkOutput("d_rdata", d_rdata, exp_drd);
      end
      if (rst) begin
        clear_left = 256; done_q = 0; prev_d = 1; exp_irv = 0; exp_drv = 0; model_valid = 1;
      end else begin
        exp_irv = e_i;
        exp_drv = e_d && !d_we;
        if (e_i) exp_ird = shadow[(i_addr / 4) % 256];
        if (e_d && !d_we) exp_drd = shadow[(d_addr / 4) % 256];
        if (clear_left > 0) begin
          clear_left--;
          if (clear_left == 0) begin
            done_q = 1;
            for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
          end
        end else begin
          done_q = 1;
          if (e_d && d_we)
            for (int k = 0; k < 4; k++)
              if (d_be[k]) shadow[(d_addr / 4) % 256][8*k +: 8] = d_wdata[8*k +: 8];
          if (e_i) prev_d = 0;
          else if (e_d) prev_d = 1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic [3:0] db, input logic [31:0] da,
                               input logic [31:0] dd);
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dd;
  endtask

  task automatic idle();
    applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask
  task automatic fetch(input logic [31:0] a);
    applyStimulus(1, a, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask
  task automatic dread(input logic [31:0] a);
    applyStimulus(0, 32'h0, 1, 0, 4'h0, a, 32'h0);
  endtask
  task automatic dwrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    applyStimulus(0, 32'h0, 1, 1, be, a, d);
  endtask

  initial begin
    logic [3:0] pat_i;
    pat_i = 4'b0101;
    rst = 1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    idle();
    // Sweep: fetch held high must not be granted until the array is zeroed.
    fetch(32'h3FC);
    rst = 0;
    for (int c = 0; c < 256; c++) begin
      if (c > 0) fetch(32'h3FC);
      @(negedge clk);
      checkOutput("clear_no_gnt", i_gnt, 1'b0);
      if (c == 0) checkOutput("clear_first_addr", mem_a, 8'h00);
      if (c == 255) checkOutput("init_before_end", init_done, 1'b0);
    end
    fetch(32'h3FC);
    @(negedge clk);
    checkOutput("first_fetch_gnt", i_gnt, 1'b1);
    checkOutput("init_done_rise", init_done, 1'b1);
    idle();
    @(negedge clk);
    checkOutput("cleared_rvalid", i_rvalid, 1'b1);
    checkOutput("cleared_data", i_rdata, 32'h0000_0000);

    dwrite(32'h10, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("wr_gnt", d_gnt, 1'b1);
    dread(32'h10);
    @(negedge clk);
    checkOutput("rd_gnt", d_gnt, 1'b1);
    checkOutput("no_rvalid_after_wr", d_rvalid, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("rd_rvalid", d_rvalid, 1'b1);
    checkOutput("rd_data", d_rdata, 32'hDEAD_BEEF);

    dwrite(32'h10, 4'hF, 32'h1122_3344);
    dwrite(32'h10, 4'b0101, 32'hAABB_CCDD);
    dread(32'h10);
    idle();
    @(negedge clk);
    checkOutput("be_merge", d_rdata, 32'h11BB_33DD);

    dwrite(32'h0, 4'hF, 32'h1000_0001);
    dwrite(32'h4, 4'hF, 32'h1000_0002);
    dwrite(32'h8, 4'hF, 32'h1000_0003);
    fetch(32'h0);
    @(negedge clk);
    checkOutput("b2b_gnt0", i_gnt, 1'b1);
    fetch(32'h4);
    @(negedge clk);
    checkOutput("b2b_gnt1", i_gnt, 1'b1);
    checkOutput("b2b_data0", i_rdata, 32'h1000_0001);
    fetch(32'h8);
    @(negedge clk);
    checkOutput("b2b_gnt2", i_gnt, 1'b1);
    checkOutput("b2b_data1", i_rdata, 32'h1000_0002);
    idle();
    @(negedge clk);
    checkOutput("b2b_rvalid2", i_rvalid, 1'b1);
    checkOutput("b2b_data2", i_rdata, 32'h1000_0003);
    idle();
    @(negedge clk);
    checkOutput("b2b_rvalid_end", i_rvalid, 1'b0);

    // Reset arriving with a read request: no grant, no response, sweep restarts at 0.
    dread(32'h10);
    rst = 1;
    @(negedge clk);
    checkOutput("rst_no_gnt", d_gnt, 1'b0);
    checkOutput("rst_cen", mem_cen, 1'b1);
    idle();
    rst = 0;
    @(negedge clk);
    checkOutput("rst_no_rvalid", d_rvalid, 1'b0);
    checkOutput("reclear_addr", mem_a, 8'h00);
    checkOutput("reclear_cen", mem_cen, 1'b0);
    checkOutput("reclear_init", init_done, 1'b0);
    for (int c = 1; c < 256; c++) idle();

    dwrite(32'h4, 4'hF, 32'h0BAD_F00D);
    dwrite(32'h8, 4'hF, 32'hCAFE_0002);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h8, 1, 0, 4'h0, 32'h4, 32'h0);
      @(negedge clk);
      checkOutput($sformatf("rr_i_gnt%0d", k), i_gnt, pat_i[k]);
      checkOutput($sformatf("rr_d_gnt%0d", k), d_gnt, !pat_i[k]);
      if (k > 0) begin
        checkOutput($sformatf("rr_i_rv%0d", k), i_rvalid, pat_i[k-1]);
        checkOutput($sformatf("rr_d_rv%0d", k), d_rvalid, !pat_i[k-1]);
      end
      if (k == 1) checkOutput("rr_i_data", i_rdata, 32'hCAFE_0002);
      if (k == 2) checkOutput("rr_d_data", d_rdata, 32'h0BAD_F00D);
    end
    idle();
    @(negedge clk);
    checkOutput("rr_last_d_rv", d_rvalid, 1'b1);

    dwrite(32'h8, 4'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("be0_gnt", d_gnt, 1'b1);
    dread(32'h8);
    idle();
    @(negedge clk);
    checkOutput("be0_unchanged", d_rdata, 32'hCAFE_0002);
    idle();
    idle();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
